// File: rtl/fpww_pkg.sv
// Shared types and constants for the alarm sequencer slice:
// controller state encoding, default ring/snooze lengths and timer width.
package fpww_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarmState_t;

  localparam int DEFAULT_RING_SECS   = 60;
  localparam int DEFAULT_SNOOZE_SECS = 300;
  localparam int TIMER_WIDTH         = 9;

endpackage

// File: rtl/alarm_timer.sv
// Seconds down-counter: loads a start value, counts down on each 1 Hz tick
// and flags expiry on the tick that takes it from 1 to 0.
module alarm_timer
  import fpww_pkg::*;
(
  input  logic                   uclock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [TIMER_WIDTH-1:0] load_value,
  input  logic                   tick,
  output logic                   expire,
  output logic [TIMER_WIDTH-1:0] count
);

  // A load wins over a same-cycle tick; the count parks at zero instead of wrapping.
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expire = tick && (count == TIMER_WIDTH'(1));

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm clock controller: arms/disarms, rings on the rising edge of a time match,
// supports snooze and dismiss, and auto-stops a ring after a fixed time.
module alarm_sequencer
  import fpww_pkg::*;
#(
  parameter int RING_SECS   = DEFAULT_RING_SECS,
  parameter int SNOOZE_SECS = DEFAULT_SNOOZE_SECS
) (
  input  logic       uclock,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic [3:0] t0,
  input  logic [3:0] t1,
  input  logic [3:0] t2,
  input  logic [3:0] t3,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
  input  logic [3:0] a2,
  input  logic [3:0] a3,
  input  logic       arm_btn,
  input  logic       snooze_btn,
  input  logic       dismiss_btn,
  output logic       alarmStatus,
  output logic       alarmRing,
  output logic       buzzer,
  output logic       snoozing
);

  if ((RING_SECS < 1) || (RING_SECS > 511) || (SNOOZE_SECS < 1) || (SNOOZE_SECS > 511)) begin : gBadParam
    $error("alarm_sequencer: RING_SECS and SNOOZE_SECS must lie in 1..511");
  end

  localparam logic [TIMER_WIDTH-1:0] RING_LOAD   = TIMER_WIDTH'(RING_SECS);
  localparam logic [TIMER_WIDTH-1:0] SNOOZE_LOAD = TIMER_WIDTH'(SNOOZE_SECS);

  alarmState_t            state, nextState;
  logic                   beat, nextBeat;
  logic                   match, matchQ, trigger;
  logic                   timerLoad, timerExpire;
  logic [TIMER_WIDTH-1:0] timerLoadValue, timerCount;

  assign match   = (a0 == t0) && (a1 == t1) && (a2 == t2) && (a3 == t3);
  assign trigger = match && !matchQ;

  alarm_timer uTimer (
    .uclock     (uclock),
    .reset      (reset),
    .load       (timerLoad),
    .load_value (timerLoadValue),
    .tick       (tick_1hz),
    .expire     (timerExpire),
    .count      (timerCount)
  );

  // matchQ resets high so a time already equal to the alarm cannot trigger on release.
  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      beat   <= 1'b0;
      matchQ <= 1'b1;
    end else begin
      state  <= nextState;
      beat   <= nextBeat;
      matchQ <= match;
    end
  end

  // Button priority in RINGING and SNOOZE is arm > dismiss > snooze > timer expiry.
  always_comb begin
    nextState      = state;
    timerLoad      = 1'b0;
    timerLoadValue = '0;
    case (state)
      IDLE: begin
        if (arm_btn) nextState = ARMED;
      end
      ARMED: begin
        if (arm_btn) begin
          nextState = IDLE;
        end else if (trigger) begin
          nextState      = RINGING;
          timerLoad      = 1'b1;
          timerLoadValue = RING_LOAD;
        end
      end
      RINGING: begin
        if (arm_btn) begin
          nextState = IDLE;
        end else if (dismiss_btn) begin
          nextState = ARMED;
        end else if (snooze_btn) begin
          nextState      = SNOOZE;
          timerLoad      = 1'b1;
          timerLoadValue = SNOOZE_LOAD;
        end else if (timerExpire) begin
          nextState = ARMED;
        end
      end
      SNOOZE: begin
        if (arm_btn) begin
          nextState = IDLE;
        end else if (dismiss_btn) begin
          nextState = ARMED;
        end else if (timerExpire) begin
          nextState      = RINGING;
          timerLoad      = 1'b1;
          timerLoadValue = RING_LOAD;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Beat starts low on every entry to RINGING so the first second is silent.
  always_comb begin
    nextBeat = 1'b0;
    if ((state == RINGING) && (nextState == RINGING)) begin
      nextBeat = beat ^ tick_1hz;
    end
  end

  always_ff @(posedge uclock or posedge reset) begin
    if (reset) begin
      alarmStatus <= 1'b0;
      alarmRing   <= 1'b0;
      buzzer      <= 1'b0;
      snoozing    <= 1'b0;
    end else begin
      alarmStatus <= (nextState != IDLE);
      alarmRing   <= (nextState == RINGING);
      buzzer      <= (nextState == RINGING) && nextBeat;
      snoozing    <= (nextState == SNOOZE);
    end
  end

  timerLiveWhileActive: assert property (
    @(posedge uclock) disable iff (reset)
      ((state == RINGING) || (state == SNOOZE)) |-> (timerCount != '0)
  );

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed self-checking bench for alarm_sequencer; each scenario task checks the
// output vector {alarmStatus, alarmRing, buzzer, snoozing} against hand-computed values.
module tb_alarm_sequencer;

  logic       uclock = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic [3:0] t0, t1, t2, t3;
  logic [3:0] a0, a1, a2, a3;
  logic       arm_btn, snooze_btn, dismiss_btn;
  logic       alarmStatus, alarmRing, buzzer, snoozing;
  logic [3:0] outs;

  int checks = 0;
  int errors = 0;

  assign outs = {alarmStatus, alarmRing, buzzer, snoozing};

  alarm_sequencer dut (
    .uclock      (uclock),
    .reset       (reset),
    .tick_1hz    (tick_1hz),
    .t0          (t0),
    .t1          (t1),
    .t2          (t2),
    .t3          (t3),
    .a0          (a0),
    .a1          (a1),
    .a2          (a2),
    .a3          (a3),
    .arm_btn     (arm_btn),
    .snooze_btn  (snooze_btn),
    .dismiss_btn (dismiss_btn),
    .alarmStatus (alarmStatus),
    .alarmRing   (alarmRing),
    .buzzer      (buzzer),
    .snoozing    (snoozing)
  );

  always #5 uclock = ~uclock;

  // Stimulus helpers: advance one clock and settle 1 time unit past the edge.
  task automatic cycle();
    @(posedge uclock);
    #1;
  endtask

  task automatic setTime(input logic [3:0] h1, input logic [3:0] h0,
                         input logic [3:0] m1, input logic [3:0] m0);
    t3 = h1; t2 = h0; t1 = m1; t0 = m0;
  endtask

  task automatic doTicks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      cycle();
      tick_1hz = 1'b0;
      cycle();
    end
  endtask

  task automatic pressArm();
    arm_btn = 1'b1;
    cycle();
    arm_btn = 1'b0;
  endtask

  task automatic pressSnooze();
    snooze_btn = 1'b1;
    cycle();
    snooze_btn = 1'b0;
  endtask

  task automatic pressDismiss();
    dismiss_btn = 1'b1;
    cycle();
    dismiss_btn = 1'b0;
  endtask

  // Move time off the alarm value and back so a fresh match edge occurs.
  task automatic retrigger();
    setTime(4'd1, 4'd2, 4'd0, 4'd1);
    cycle();
    setTime(4'd1, 4'd2, 4'd0, 4'd0);
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_assert: got %b expected 0000", outs);
    end
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_release: got %b expected 0000", outs);
    end
  endtask

  task automatic test_ring();
    setTime(4'd1, 4'd1, 4'd5, 4'd9);
    cycle();
    pressArm();
    checks++;
    if (outs !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL arm: got %b expected 1000", outs);
    end
    setTime(4'd1, 4'd2, 4'd0, 4'd0);
    cycle();
    checks++;
    if (outs !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL ring_start: got %b expected 1100", outs);
    end
    doTicks(1);
    checks++;
    if (outs !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL beat_second: got %b expected 1110", outs);
    end
    doTicks(1);
    checks++;
    if (outs !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL beat_third: got %b expected 1100", outs);
    end
  endtask

  task automatic test_auto_stop();
    doTicks(57);
    checks++;
    if (outs !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL ring_tick59: got %b expected 1110", outs);
    end
    doTicks(1);
    checks++;
    if (outs !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL auto_stop: got %b expected 1000", outs);
    end
    repeat (5) cycle();
    checks++;
    if (outs !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL no_retrigger: got %b expected 1000", outs);
    end
  endtask

  task automatic test_snooze();
    retrigger();
    checks++;
    if (outs !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL snooze_ring: got %b expected 1100", outs);
    end
    pressSnooze();
    checks++;
    if (outs !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL snooze_enter: got %b expected 1001", outs);
    end
    doTicks(150);
    pressSnooze();
    doTicks(149);
    checks++;
    if (outs !== 4'b1001) begin
      errors++;
      $display("[TB] FAIL snooze_tick299: got %b expected 1001", outs);
    end
    doTicks(1);
    checks++;
    if (outs !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL rering: got %b expected 1100", outs);
    end
    doTicks(59);
    checks++;
    if (outs !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL rering_tick59: got %b expected 1110", outs);
    end
    doTicks(1);
    checks++;
    if (outs !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL rering_stop: got %b expected 1000", outs);
    end
  endtask

  task automatic test_conflicts();
    retrigger();
    snooze_btn  = 1'b1;
    dismiss_btn = 1'b1;
    cycle();
    snooze_btn  = 1'b0;
    dismiss_btn = 1'b0;
    checks++;
    if (outs !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL snooze_dismiss: got %b expected 1000", outs);
    end
    retrigger();
    arm_btn     = 1'b1;
    dismiss_btn = 1'b1;
    cycle();
    arm_btn     = 1'b0;
    dismiss_btn = 1'b0;
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL arm_dismiss: got %b expected 0000", outs);
    end
  endtask

  task automatic test_dismiss_snooze();
    pressArm();
    retrigger();
    pressSnooze();
    doTicks(3);
    pressDismiss();
    checks++;
    if (outs !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL dismiss_snooze: got %b expected 1000", outs);
    end
  endtask

  task automatic test_reset_in_snooze();
    retrigger();
    pressSnooze();
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_snooze: got %b expected 0000", outs);
    end
    cycle();
    reset = 1'b0;
    repeat (3) cycle();
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_release_match: got %b expected 0000", outs);
    end
    pressArm();
    repeat (3) cycle();
    checks++;
    if (outs !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL arm_after_reset: got %b expected 1000", outs);
    end
    retrigger();
    checks++;
    if (outs !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL ring_after_reset: got %b expected 1100", outs);
    end
  endtask

  task automatic test_idle_pass();
    pressArm();
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL disarm_ring: got %b expected 0000", outs);
    end
    setTime(4'd1, 4'd1, 4'd5, 4'd9);
    cycle();
    setTime(4'd1, 4'd2, 4'd0, 4'd0);
    cycle();
    doTicks(2);
    checks++;
    if (outs !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL idle_pass: got %b expected 0000", outs);
    end
  endtask

  initial begin
    reset       = 1'b1;
    tick_1hz    = 1'b0;
    arm_btn     = 1'b0;
    snooze_btn  = 1'b0;
    dismiss_btn = 1'b0;
    setTime(4'd1, 4'd1, 4'd5, 4'd9);
    a3 = 4'd1; a2 = 4'd2; a1 = 4'd0; a0 = 4'd0;
    test_reset();
    test_ring();
    test_auto_stop();
    test_snooze();
    test_conflicts();
    test_dismiss_snooze();
    test_reset_in_snooze();
    test_idle_pass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_sequencer.md
ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter RING_SECS, default 60: seconds a ring lasts before auto-stop.
REQ-002 Parameter SNOOZE_SECS, default 300: seconds a snooze lasts before re-ring.
REQ-003 uclock  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 tick_1hz  in  1  one-uclock-wide pulse once per second.
REQ-006 t0,t1,t2,t3  in  4 each  current time BCD digits.
REQ-007 a0,a1,a2,a3  in  4 each  alarm time BCD digits.
REQ-008 arm_btn  in  1  one-cycle pulse; toggles armed/disarmed.
REQ-009 snooze_btn  in  1  one-cycle pulse; snoozes an active ring.
REQ-010 dismiss_btn  in  1  one-cycle pulse; ends an active ring or snooze.
REQ-011 alarmStatus  out  1  high while armed (ARMED, RINGING, SNOOZE).
REQ-012 alarmRing  out  1  high in RINGING.
REQ-013 buzzer  out  1  ring beat: alarmRing AND beat phase.
REQ-014 snoozing  out  1  high in SNOOZE.

Function
REQ-015 States SHALL be IDLE, ARMED, RINGING, SNOOZE; all outputs registered, decoded from state and beat.
REQ-016 match = (a0..a3 equal t0..t3); match_q SHALL be match delayed one uclock.
REQ-017 Trigger SHALL be match AND NOT match_q (rising edge only); a persisting match never retriggers.
REQ-018 IDLE: arm_btn -> ARMED; other buttons ignored.
REQ-019 ARMED: trigger -> RINGING, timer loaded RING_SECS, beat cleared; arm_btn -> IDLE.
REQ-020 RINGING: priority arm_btn > dismiss_btn > snooze_btn > timeout, same-cycle conflicts resolved by this order.
REQ-021 RINGING: arm_btn -> IDLE; dismiss_btn -> ARMED; snooze_btn -> SNOOZE, timer loaded SNOOZE_SECS; timer expiry -> ARMED.
REQ-022 SNOOZE: arm_btn -> IDLE; dismiss_btn -> ARMED; timer expiry -> RINGING, timer reloaded RING_SECS, beat cleared; snooze_btn ignored.
REQ-023 Timer SHALL be a 9-bit down counter decremented only on tick_1hz; expiry = tick_1hz while count==1; no wrap below 0.
REQ-024 Timer load SHALL take priority over decrement in the same cycle.
REQ-025 Trigger SHALL be ignored in IDLE, RINGING and SNOOZE.
REQ-026 Beat SHALL toggle on each tick_1hz in RINGING, held 0 otherwise; first second of a ring is silent, second sounds.
REQ-027 Output latency: outputs SHALL reflect a transition one uclock after the causing input is sampled.
REQ-028 Parameters SHALL be restricted to 1..511.

Reset
REQ-029 reset SHALL force state IDLE, timer 0, beat 0, match_q 1 asynchronously.
REQ-030 During/after reset all outputs SHALL be 0; match_q=1 prevents a spurious trigger on release when time already equals alarm.
REQ-031 Reset asserted mid-ring or mid-snooze SHALL abort it; armed status is not retained.

Structure
REQ-032 State encoding enum and default RING_SECS/SNOOZE_SECS constants SHALL live in shared package fpww_pkg.
REQ-033 The seconds timer SHALL be sub-module alarm_timer (load, load_value, tick, expire, 9-bit count).
REQ-034 No clock other than uclock; buttons are synchronised upstream.

Verification
REQ-035 Reset, arm_btn, set a=t=12:00 via time increment -> alarmRing=1 one cycle after match edge; buzzer 0 first second, 1 second second.
REQ-036 Ringing, no input, 60 ticks -> back to ARMED, alarmRing=0, alarmStatus=1; match still true -> no retrigger.
REQ-037 Ringing, snooze_btn -> snoozing=1 for 300 ticks, then alarmRing=1 with full 60-tick ring.
REQ-038 Ringing, snooze_btn and dismiss_btn same cycle -> ARMED, snoozing=0; arm_btn+dismiss_btn same cycle -> IDLE, alarmStatus=0.
REQ-039 Reset asserted in SNOOZE with time==alarm, released -> all outputs 0, no trigger until arm_btn and next match edge.
REQ-040 Disarmed (IDLE) time passes through alarm value -> alarmRing and buzzer stay 0.
